// File: rtl/ghash_accumulator.sv
// GHASH front-end: pads and absorbs AAD/CT blocks into Y via an external GF(2^128) multiplier, then folds in the length block.
// Optional AAD-after-CT ordering check is enabled with `define GHASH_ORDER_CHECK_EN.
module ghash_accumulator #(
    parameter int DATA_WIDTH = 128,
    parameter int CNT_WIDTH  = 61
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] h_i,
    input  logic                  blk_valid_i,
    output logic                  blk_ready_o,
    input  logic [DATA_WIDTH-1:0] blk_data_i,
    input  logic [4:0]            blk_nbytes_i,
    input  logic                  blk_is_ct_i,
    input  logic                  blk_last_i,
    output logic [DATA_WIDTH-1:0] mul_h_o,
    output logic [DATA_WIDTH-1:0] mul_a_o,
    input  logic [DATA_WIDTH-1:0] mul_x_i,
    output logic                  tag_valid_o,
    output logic [DATA_WIDTH-1:0] tag_o,
    output logic                  err_o
);

    typedef enum logic [2:0] {IDLE, ABSORB, MUL, LEN, LMUL, DONE} state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] h_q, y_q, x_q;
    logic [CNT_WIDTH-1:0]  aad_cnt, ct_cnt;
    logic                  last_q;
    logic                  hs, ooo, absorb;
    logic [4:0]            nb;
    logic [DATA_WIDTH-1:0] pad;
    logic [63:0]           aad_bits, ct_bits;

    assign mul_h_o = h_q;
    assign mul_a_o = x_q;
    assign tag_o   = y_q;

    assign hs       = blk_valid_i && (state == ABSORB);
    assign nb       = (blk_nbytes_i > 5'd16) ? 5'd16 : blk_nbytes_i;
    assign absorb   = hs && (nb != 5'd0) && !ooo;
    assign aad_bits = 64'({aad_cnt, 3'b000});
    assign ct_bits  = 64'({ct_cnt, 3'b000});

    // Byte 0 sits in the top byte lane; bytes at or beyond nb are zeroed.
    always_comb begin
        pad = blk_data_i;
        for (int i = 0; i < 16; i++) begin
            if (5'(i) >= nb) pad[DATA_WIDTH-1-8*i -: 8] = 8'h00;
        end
    end

`ifdef GHASH_ORDER_CHECK_EN
    logic seen_ct, err_q;
    assign ooo   = !blk_is_ct_i && seen_ct;
    assign err_o = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            seen_ct <= 1'b0;
            err_q   <= 1'b0;
        end else if (start_i && (state == IDLE || state == DONE)) begin
            seen_ct <= 1'b0;
            err_q   <= 1'b0;
        end else if (hs) begin
            seen_ct <= seen_ct | blk_is_ct_i;
            err_q   <= err_q | ooo;
        end
    end
`else
    assign ooo   = 1'b0;
    assign err_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        blk_ready_o = 1'b0;
        tag_valid_o = 1'b0;
        case (state)
            IDLE:   if (start_i) state_nxt = ABSORB;
            ABSORB: begin
                blk_ready_o = 1'b1;
                if (absorb)                 state_nxt = MUL;
                else if (hs && blk_last_i)  state_nxt = LEN;
            end
            MUL:    state_nxt = last_q ? LEN : ABSORB;
            LEN:    state_nxt = LMUL;
            LMUL:   state_nxt = DONE;
            DONE: begin
                tag_valid_o = 1'b1;
                if (start_i) state_nxt = ABSORB;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_q     <= '0;
            y_q     <= '0;
            x_q     <= '0;
            aad_cnt <= '0;
            ct_cnt  <= '0;
            last_q  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: if (start_i) begin
                    h_q     <= h_i;
                    y_q     <= '0;
                    x_q     <= '0;
                    aad_cnt <= '0;
                    ct_cnt  <= '0;
                    last_q  <= 1'b0;
                end
                ABSORB: if (absorb) begin
                    x_q    <= y_q ^ pad;
                    last_q <= blk_last_i;
                    if (blk_is_ct_i) ct_cnt  <= ct_cnt + CNT_WIDTH'(nb);
                    else             aad_cnt <= aad_cnt + CNT_WIDTH'(nb);
                end
                MUL:  y_q <= mul_x_i;
                LEN:  x_q <= y_q ^ {aad_bits, ct_bits};
                LMUL: y_q <= mul_x_i;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ghash_accumulator.sv
// Directed bench for ghash_accumulator; supplies a behavioural GF(2^128) multiplier on the mul_* ports.
module tb_ghash_accumulator;

    logic         clk, rst, start_i, blk_valid_i, blk_ready_o, blk_is_ct_i, blk_last_i;
    logic         tag_valid_o, err_o;
    logic [127:0] h_i, blk_data_i, mul_h_o, mul_a_o, mul_x_i, tag_o;
    logic [4:0]   blk_nbytes_i;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [127:0] HK   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] CT0  = 128'h0388dace60b6a392f328c2b971b2fe78;
    localparam logic [127:0] TAG1 = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;

    ghash_accumulator dut (
        .clk(clk), .rst(rst), .start_i(start_i), .h_i(h_i),
        .blk_valid_i(blk_valid_i), .blk_ready_o(blk_ready_o), .blk_data_i(blk_data_i),
        .blk_nbytes_i(blk_nbytes_i), .blk_is_ct_i(blk_is_ct_i), .blk_last_i(blk_last_i),
        .mul_h_o(mul_h_o), .mul_a_o(mul_a_o), .mul_x_i(mul_x_i),
        .tag_valid_o(tag_valid_o), .tag_o(tag_o), .err_o(err_o)
    );

    // GCM bit order: bit 0 of the field element is the MSB of the vector.
    function automatic logic [127:0] gf_mul(input logic [127:0] x, input logic [127:0] y);
        logic [127:0] z, v;
        z = '0;
        v = y;
        for (int i = 0; i < 128; i++) begin
            if (x[127-i]) z = z ^ v;
            if (v[0]) v = (v >> 1) ^ {8'he1, 120'd0};
            else      v = v >> 1;
        end
        return z;
    endfunction

    assign mul_x_i = gf_mul(mul_a_o, mul_h_o);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [127:0] h);
        h_i = h;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    // Returns one cycle after the handshake edge.
    task automatic send(input logic [127:0] d, input logic [4:0] nb, input logic ct, input logic last);
        int n;
        n = 0;
        blk_valid_i = 1'b1; blk_data_i = d; blk_nbytes_i = nb; blk_is_ct_i = ct; blk_last_i = last;
        while (!blk_ready_o && n < 20) begin
            tick();
            n++;
        end
        if (!blk_ready_o) begin
            n_chk++; n_fail++;
            $display("FAIL send_timeout: blk_ready_o got %b required 1", blk_ready_o);
        end else begin
            tick();
        end
        blk_valid_i = 1'b0; blk_last_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        n_chk++; if (blk_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b required 0", blk_ready_o); end
        n_chk++; if (tag_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_tag_valid: got %b required 0", tag_valid_o); end
        n_chk++; if (tag_o !== 128'd0) begin n_fail++; $display("FAIL reset_tag: got %h required 0", tag_o); end
        n_chk++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b required 0", err_o); end
    endtask

    task automatic test_empty();
        do_start(HK);
        n_chk++; if (blk_ready_o !== 1'b1) begin n_fail++; $display("FAIL empty_ready: got %b required 1", blk_ready_o); end
        send(128'hdeadbeef, 5'd0, 1'b0, 1'b1);
        tick();
        n_chk++; if (tag_valid_o !== 1'b0) begin n_fail++; $display("FAIL empty_early: tag_valid got %b required 0 at T+2", tag_valid_o); end
        tick();
        n_chk++; if (tag_valid_o !== 1'b1) begin n_fail++; $display("FAIL empty_latency: tag_valid got %b required 1 at T+3", tag_valid_o); end
        n_chk++; if (tag_o !== 128'd0) begin n_fail++; $display("FAIL empty_tag: got %h required 0", tag_o); end
        tick(); tick();
        n_chk++; if (tag_valid_o !== 1'b1) begin n_fail++; $display("FAIL empty_hold: tag_valid got %b required 1", tag_valid_o); end
    endtask

    task automatic test_single_ct();
        do_start(HK);
        send(CT0, 5'd16, 1'b1, 1'b1);
        tick(); tick();
        n_chk++; if (tag_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_early: tag_valid got %b required 0 at T+3", tag_valid_o); end
        tick();
        n_chk++; if (tag_valid_o !== 1'b1) begin n_fail++; $display("FAIL single_latency: tag_valid got %b required 1 at T+4", tag_valid_o); end
        n_chk++; if (tag_o !== TAG1) begin n_fail++; $display("FAIL single_tag: got %h required %h", tag_o, TAG1); end
    endtask

    task automatic test_partial();
        logic [127:0] y1, lx, s;
        y1 = gf_mul({CT0[127:64], 64'd0}, HK);
        lx = y1 ^ {64'd0, 64'd64};
        s  = gf_mul(lx, HK);
        do_start(HK);
        send({CT0[127:64], 64'hffffffffffffffff}, 5'd8, 1'b1, 1'b1);
        tick(); tick();
        n_chk++; if (mul_a_o !== lx) begin n_fail++; $display("FAIL partial_len_block: mul_a got %h required %h", mul_a_o, lx); end
        tick();
        n_chk++; if (tag_o !== s || tag_valid_o !== 1'b1) begin
            n_fail++; $display("FAIL partial_tag: got %h v=%b required %h v=1", tag_o, tag_valid_o, s);
        end
    endtask

    task automatic test_clamp_skip();
        do_start(HK);
        // start while absorbing must be ignored; a zero H would collapse the tag to 0
        do_start(128'd0);
        send(128'h0123456789abcdef0123456789abcdef, 5'd0, 1'b1, 1'b0);
        send(CT0, 5'd31, 1'b1, 1'b1);
        tick(); tick(); tick();
        n_chk++; if (tag_o !== TAG1 || tag_valid_o !== 1'b1) begin
            n_fail++; $display("FAIL clamp_skip_tag: got %h v=%b required %h v=1", tag_o, tag_valid_o, TAG1);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] a [3];
        logic [127:0] y, lx;
        logic [4:0]   rd;
        int k, hs;
        a[0] = 128'h00112233445566778899aabbccddeeff;
        a[1] = 128'hfeedfacedeadbeefabaddad201234567;
        a[2] = 128'h5a5a5a5a0f0f0f0f3c3c3c3c96969696;
        y = '0;
        for (int i = 0; i < 3; i++) y = gf_mul(y ^ a[i], HK);
        lx = y ^ {64'd384, 64'd0};
        k = 0; hs = 0; rd = '0;
        do_start(HK);
        blk_valid_i = 1'b1; blk_data_i = a[0]; blk_nbytes_i = 5'd16; blk_is_ct_i = 1'b0; blk_last_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            rd[c] = blk_ready_o;
            if (blk_ready_o && blk_valid_i) hs++;
            tick();
            if (rd[c]) begin
                k++;
                if (k < 3) begin
                    blk_data_i = a[k];
                    blk_last_i = (k == 2);
                end else begin
                    blk_valid_i = 1'b0;
                    blk_last_i = 1'b0;
                end
            end
        end
        n_chk++; if (rd !== 5'b10101) begin n_fail++; $display("FAIL b2b_ready_pattern: got %b required 10101", rd); end
        n_chk++; if (hs !== 3) begin n_fail++; $display("FAIL b2b_handshakes: got %0d required 3", hs); end
        tick(); tick();
        n_chk++; if (mul_a_o !== lx) begin n_fail++; $display("FAIL b2b_len_block: mul_a got %h required %h", mul_a_o, lx); end
        tick();
        n_chk++; if (tag_o !== gf_mul(lx, HK) || tag_valid_o !== 1'b1) begin
            n_fail++; $display("FAIL b2b_tag: got %h v=%b required %h v=1", tag_o, tag_valid_o, gf_mul(lx, HK));
        end
    endtask

    task automatic test_reset_mid();
        do_start(HK);
        send(CT0, 5'd16, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_chk++; if (blk_ready_o !== 1'b0) begin n_fail++; $display("FAIL midrst_ready: got %b required 0", blk_ready_o); end
        n_chk++; if (tag_o !== 128'd0) begin n_fail++; $display("FAIL midrst_tag: got %h required 0", tag_o); end
        n_chk++; if (mul_h_o !== 128'd0) begin n_fail++; $display("FAIL midrst_h: got %h required 0", mul_h_o); end
        tick();
        n_chk++; if (blk_ready_o !== 1'b0) begin n_fail++; $display("FAIL midrst_idle: ready got %b required 0", blk_ready_o); end
        do_start(HK);
        send(CT0, 5'd16, 1'b1, 1'b1);
        tick(); tick(); tick();
        n_chk++; if (tag_o !== TAG1 || tag_valid_o !== 1'b1) begin
            n_fail++; $display("FAIL midrst_restart_tag: got %h v=%b required %h v=1", tag_o, tag_valid_o, TAG1);
        end
    endtask

    task automatic test_order();
        logic [127:0] aadb, s, y;
        logic         e;
        aadb = 128'hcafebabe00000000cafebabe11111111;
        do_start(HK);
        send(CT0, 5'd16, 1'b1, 1'b0);
        send(aadb, 5'd16, 1'b0, 1'b1);
`ifdef GHASH_ORDER_CHECK_EN
        s = TAG1;
        e = 1'b1;
        y = '0;
        tick(); tick();
`else
        y = gf_mul(gf_mul(CT0, HK) ^ aadb, HK);
        s = gf_mul(y ^ {64'd128, 64'd128}, HK);
        e = 1'b0;
        tick(); tick(); tick();
`endif
        n_chk++; if (err_o !== e) begin n_fail++; $display("FAIL order_err: got %b required %b", err_o, e); end
        n_chk++; if (tag_o !== s || tag_valid_o !== 1'b1) begin
            n_fail++; $display("FAIL order_tag: got %h v=%b required %h v=1", tag_o, tag_valid_o, s);
        end
        do_start(HK);
        n_chk++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL order_err_clear: got %b required 0", err_o); end
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; h_i = '0; blk_valid_i = 1'b0; blk_data_i = '0;
        blk_nbytes_i = '0; blk_is_ct_i = 1'b0; blk_last_i = 1'b0;
        #1;
        test_reset();
        test_empty();
        test_single_ct();
        test_partial();
        test_clamp_skip();
        test_back_to_back();
        test_reset_mid();
        test_order();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ghash_accumulator.md
Name: ghash_accumulator

Overview:
- GHASH front-end controller that sits directly upstream of the combinational GF(2^128) multiplier.
- Accepts a stream of AAD and ciphertext blocks on a valid/ready interface and zero-pads partial blocks.
- Forms (Y xor X) and drives it, with the registered hash key H, into the multiplier; captures the product back into Y.
- Appends the GCM length block and presents the final GHASH value S for tag generation.

Parameters:
- DATA_WIDTH, 128, block width; only 128 is supported.
- CNT_WIDTH, 61, width of the AAD and CT byte counters; the length fields are the byte counts times 8, zero-extended to 64 bits.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start_i  in  1  pulse; captures h_i, clears Y and the counters
- h_i  in  128  hash key H = E(K, 0^128)
- blk_valid_i  in  1  block valid
- blk_ready_o  out  1  block ready
- blk_data_i  in  128  block; byte 0 in bits [127:120]
- blk_nbytes_i  in  5  valid bytes, 0..16
- blk_is_ct_i  in  1  0 = AAD, 1 = ciphertext
- blk_last_i  in  1  final data block
- mul_h_o  out  128  to the multiplier h_i
- mul_a_o  out  128  to the multiplier a_i
- mul_x_i  in  128  from the multiplier x_o (combinational product)
- tag_valid_o  out  1  S valid
- tag_o  out  128  GHASH result S
- err_o  out  1  ordering error (optional feature only)

Behaviour:
- Clocking and reset: single clock domain. Reset is synchronous and active-high. rst has priority over every other input.
- Reset values: state = IDLE; H, Y, X register and both counters = 0; blk_ready_o = 0; tag_valid_o = 0; tag_o = 0; err_o = 0.
- Continuous outputs: mul_h_o = H register, mul_a_o = X register, tag_o = Y.
- States: IDLE, ABSORB, MUL, LEN, LMUL, DONE.
- IDLE / DONE: start_i loads H <= h_i and zeroes Y, X, counters and err_o, then moves to ABSORB. start_i is ignored in every other state.
- ABSORB: blk_ready_o = 1; a handshake occurs when valid and ready are both high.
  - Padding: pad = blk_data_i with bytes nbytes..15 forced to 0.
  - nbytes > 0: X <= Y ^ pad; the AAD or CT counter (per blk_is_ct_i) += nbytes; go to MUL.
  - nbytes == 0 with last = 1: no XOR, no multiply, counters unchanged; go to LEN. This is how an empty message is finalized.
  - nbytes == 0 with last = 0: the block is consumed and ignored.
  - nbytes > 16: treated as 16.
- MUL: blk_ready_o = 0; Y <= mul_x_i. Go to LEN if the accepted block had last set, otherwise back to ABSORB. Throughput is one block per 2 cycles.
- LEN: X <= Y ^ {aad_bytes*8 (64b), ct_bytes*8 (64b)}; go to LMUL.
- LMUL: Y <= mul_x_i; go to DONE.
- DONE: tag_valid_o = 1 and is held until start_i or rst; tag_o = S.
- Latency: a last block accepted in cycle T (nbytes > 0) gives tag_valid_o high from T+4. The nbytes = 0 finalize gives tag_valid_o from T+3.
- Counters wrap modulo 2^CNT_WIDTH with no flag.
- Reset mid-operation: immediate return to IDLE with all reset values; any partial result is lost.
- blk_valid_i outside ABSORB is ignored; no handshake occurs.

Optional Feature:
- Macro: GHASH_ORDER_CHECK_EN.
- Defined:
  - An AAD block accepted after any CT block in the same message sets err_o (sticky until start_i or rst).
  - That block is consumed but not absorbed and not counted. If it also carries last, the FSM goes to LEN.
- Undefined: err_o is tied to 0 and out-of-order AAD blocks are absorbed and counted normally.

Test Plan:
- Empty message: H = 66e94bd4ef8a2c3b884cfa59ca342b2e, start, then one block with nbytes = 0, last = 1 -> tag_valid_o after 3 cycles, tag_o = 0.
- Single CT block: same H, C = 0388dace60b6a392f328c2b971b2fe78, nbytes = 16, is_ct = 1, last = 1 -> tag_valid_o at T+4, tag_o = f38cbb1ad69223dcc3457ae5b6b0f885.
- Partial block: same C but blk_data_i low 8 bytes = ff..ff, nbytes = 8 -> LEN block ct field = 64, and tag_o equals the result for C with low 8 bytes zeroed; compare against a software model.
- Backpressure and throughput: valid held high for 3 AAD blocks -> blk_ready_o toggles 1,0,1,0,1; exactly 3 handshakes; AAD length field = 384.
- Reset mid-MUL: assert rst in the MUL cycle -> next cycle IDLE, blk_ready_o = 0, tag_o = 0; start_i with a new message completes correctly.
- GHASH_ORDER_CHECK_EN defined: CT block then AAD block (last = 1) -> err_o = 1, and tag_o equals GHASH of the CT block alone.
